// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM that updates on the falling clock edge.
// Each transaction runs IDLE -> ACCESS -> ACK. Every output comes straight from a flop.

module ram_arbiter_port #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ack_set,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= ack_set;
            if (cap_en)
                rdata <= ram_rdata;
        end
    end
endmodule

module ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t state, state_nx;
    logic   grant, grant_nx;
    logic   last_grant, last_grant_nx;
    logic   win;
    logic   cs_nx, we_nx, busy_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;

    logic [NUM_PORTS-1:0]             req_v, we_v, ack_set, cap_en;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v;
    wire  [NUM_PORTS-1:0]             ack_v;
    wire  [NUM_PORTS-1:0][DATA_W-1:0] rdata_v;

    assign req_v   = {req1, req0};
    assign we_v    = {we1, we0};
    assign addr_v  = {addr1, addr0};
    assign wdata_v = {wdata1, wdata0};

    // On a tie the port that did not win last time gets the slot.
    assign win = (req_v == 2'b11) ? ~last_grant : req_v[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            ram_cs     <= cs_nx;
            ram_we     <= we_nx;
            ram_addr   <= addr_nx;
            ram_wdata  <= wdata_nx;
            busy       <= busy_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        cs_nx         = 1'b0;
        we_nx         = 1'b0;
        addr_nx       = ram_addr;
        wdata_nx      = ram_wdata;
        ack_set       = '0;
        cap_en        = '0;
        case (state)
            IDLE: begin
                if (|req_v) begin
                    state_nx      = ACCESS;
                    grant_nx      = win;
                    last_grant_nx = win;
                    cs_nx         = 1'b1;
                    we_nx         = we_v[win];
                    addr_nx       = addr_v[win];
                    wdata_nx      = wdata_v[win];
                end
            end
            ACCESS: begin
                // ram_rdata is only meaningful here: the RAM produced it on the preceding falling edge.
                state_nx       = ACK;
                ack_set[grant] = 1'b1;
                cap_en[grant]  = ~ram_we;
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ram_arbiter_port #(.DATA_W(DATA_W)) u_port (
            .clock     (clock),
            .reset     (reset),
            .ack_set   (ack_set[p]),
            .cap_en    (cap_en[p]),
            .ram_rdata (ram_rdata),
            .ack       (ack_v[p]),
            .rdata     (rdata_v[p])
        );
    end

    assign ack0   = ack_v[0];
    assign ack1   = ack_v[1];
    assign rdata0 = rdata_v[0];
    assign rdata1 = rdata_v[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural falling-edge RAM.
// When the RAM is not selected it drives a junk pattern.
module tb_ram_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam logic [DW-1:0] JUNK = 32'hBAD0BAD0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1, ram_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, ram_wdata, ram_rdata;
    logic ack0, ack1, ram_cs, ram_we, busy;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            ram_rdata     <= JUNK;
        end else if (ram_cs)
            ram_rdata <= mem[ram_addr];
        else
            ram_rdata <= JUNK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = v; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = v; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Uncontended single transaction with cycle-exact checks.
    task automatic xact(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
        set_req(p, 1'b1, w, a, d);
        tick;
        chk({tag, ".cs"},   ram_cs, 1);
        chk({tag, ".we"},   ram_we, w);
        chk({tag, ".addr"}, ram_addr, a);
        chk({tag, ".busy"}, busy, 1);
        if (w) chk({tag, ".wdata"}, ram_wdata, d);
        tick;
        chk({tag, ".ack"},   (p == 0) ? ack0 : ack1, 1);
        chk({tag, ".other"}, (p == 0) ? ack1 : ack0, 0);
        chk({tag, ".cs_off"}, ram_cs, 0);
        set_req(p, 1'b0, 1'b0, '0, '0);
        tick;
        chk({tag, ".ack_end"}, (p == 0) ? ack0 : ack1, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        int n, cyc, g, last_cyc;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem[3] = 32'h33333333; mem[7] = 32'h77777777;
        mem[20] = 32'h20202020; mem[21] = 32'h21212121; mem[12] = 32'h0;
        tick; tick;
        chk("rst.cs", ram_cs, 0);     chk("rst.we", ram_we, 0);
        chk("rst.ack0", ack0, 0);     chk("rst.ack1", ack1, 0);
        chk("rst.busy", busy, 0);     chk("rst.addr", ram_addr, 0);
        chk("rst.wdata", ram_wdata, 0);
        chk("rst.rdata0", rdata0, 0); chk("rst.rdata1", rdata1, 0);
        reset = 0;

        // write then read back through port 0
        xact(0, 1'b1, 11'd5, 32'hDEADBEEF, "wr0");
        chk("wr0.mem", mem[5], 32'hDEADBEEF);
        xact(0, 1'b0, 11'd5, 32'h0, "rd0");
        chk("rd0.rdata0", rdata0, 32'hDEADBEEF);

        // tie right after reset: port 0 first, port 1 three edges later
        reset = 1; tick; reset = 0;
        set_req(0, 1'b1, 1'b0, 11'd3, '0);
        set_req(1, 1'b1, 1'b0, 11'd7, '0);
        tick; chk("tie.addr0", ram_addr, 3); chk("tie.cs0", ram_cs, 1);
        tick; chk("tie.ack0", ack0, 1); chk("tie.ack1lo", ack1, 0);
        chk("tie.rdata0", rdata0, 32'h33333333);
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick; chk("tie.gap_cs", ram_cs, 0); chk("tie.gap_busy", busy, 0);
        tick; chk("tie.addr1", ram_addr, 7); chk("tie.cs1", ram_cs, 1);
        tick; chk("tie.ack1", ack1, 1); chk("tie.rdata1", rdata1, 32'h77777777);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick; chk("tie.ack1_end", ack1, 0);

        // fairness under continuous contention
        set_req(0, 1'b1, 1'b0, 11'd20, '0);
        set_req(1, 1'b1, 1'b0, 11'd21, '0);
        n = 0; cyc = 0; last_cyc = 0;
        while (n < 6 && cyc < 60) begin
            tick; cyc++;
            if (ack0 || ack1) begin
                g = ack1 ? 1 : 0;
                chk($sformatf("fair%0d.port", n), g, n % 2);
                chk($sformatf("fair%0d.both", n), ack0 & ack1, 0);
                chk($sformatf("fair%0d.rdata", n), g ? rdata1 : rdata0,
                    g ? 32'h21212121 : 32'h20202020);
                if (n > 0) chk($sformatf("fair%0d.gap", n), cyc - last_cyc, 3);
                last_cyc = cyc;
                if (n == 5) begin req0 = 0; req1 = 0; end
                n++;
            end
        end
        chk("fair.count", n, 6);
        tick;

        // port 1 write must not disturb port 0 read data
        xact(0, 1'b1, 11'd9, 32'hA5A5A5A5, "iso.wr0");
        xact(0, 1'b0, 11'd9, 32'h0, "iso.rd0");
        chk("iso.rdata0_pre", rdata0, 32'hA5A5A5A5);
        xact(1, 1'b1, 11'd10, 32'h12345678, "iso.wr1");
        chk("iso.rdata0", rdata0, 32'hA5A5A5A5);
        chk("iso.rdata1", rdata1, 32'h21212121);
        chk("iso.mem", mem[10], 32'h12345678);

        // reset mid-ACCESS of a port 1 write
        set_req(1, 1'b1, 1'b1, 11'd12, 32'hCAFEF00D);
        tick; chk("rsta.cs_before", ram_cs, 1);
        #2 reset = 1;
        #1 chk("rsta.cs", ram_cs, 0); chk("rsta.busy", busy, 0); chk("rsta.ack1", ack1, 0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick; reset = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rsta.noack%0d", i), ack1, 0);
            tick;
        end
        chk("rsta.mem", mem[12], 32'h0);
        set_req(0, 1'b1, 1'b0, 11'd3, '0);
        set_req(1, 1'b1, 1'b0, 11'd7, '0);
        tick; chk("rsta.tie_addr", ram_addr, 3);
        tick; chk("rsta.tie_ack0", ack0, 1); chk("rsta.tie_rdata0", rdata0, 32'h33333333);
        req0 = 0; req1 = 0;
        tick; tick;

        // idle bus: nothing moves, read data holds
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("idle%0d.cs", i), ram_cs, 0);
            chk($sformatf("idle%0d.busy", i), busy, 0);
            chk($sformatf("idle%0d.rd", i), {rdata1, rdata0}, {32'h0, 32'h33333333});
            chk($sformatf("idle%0d.x", i), $isunknown({rdata1, rdata0}), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; the clock and reset ports SHALL be clock and reset.
REQ-004 clock  input  1  single clock; all block state updates on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req0 / req1  input  1  port 0 / port 1 access request, level, held until ack.
REQ-007 we0 / we1  input  1  1 = write, 0 = read, valid while req high.
REQ-008 addr0 / addr1  input  ADDR_W  word address, valid while req high.
REQ-009 wdata0 / wdata1  input  DATA_W  write data, valid while req high.
REQ-010 ack0 / ack1  output  1  one-cycle completion pulse for port 0 / port 1.
REQ-011 rdata0 / rdata1  output  DATA_W  read data for port 0 / port 1, valid when the matching ack is high.
REQ-012 ram_cs  output  1  RAM chip_select.
REQ-013 ram_we  output  1  RAM write-enable.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_wdata  output  DATA_W  RAM data_in.
REQ-016 ram_rdata  input  DATA_W  RAM data_out; the RAM updates on falling clock edge.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and ACK; all outputs SHALL be registered.
REQ-019 IDLE, at least one req high -> ACCESS: latch the winner into grant, drive ram_cs=1 and ram_we/ram_addr/ram_wdata from the winner's port.
REQ-020 IDLE, no req -> stay in IDLE; ram_cs=0 and ram_we=0.
REQ-021 ACCESS -> ACK on the next edge: ram_cs=0, ram_we=0, pulse ack of the granted port.
REQ-022 On the ACCESS -> ACK edge of a read, ram_rdata SHALL be captured into rdata of the granted port (data the RAM produced on the intervening falling edge).
REQ-023 On a write, the granted port's rdata SHALL be unchanged.
REQ-024 The non-granted port's rdata SHALL be unchanged in every case.
REQ-025 ACK -> IDLE unconditionally on the next edge; ack SHALL be high for exactly one cycle.
REQ-026 Timing: request sampled at edge N; RAM access at the falling edge between N and N+1; ack high from N+1 to N+2; next grant no earlier than edge N+3.
REQ-027 The requester SHALL deassert req, or present a new request, after sampling ack high; a req still high in IDLE is treated as a new request.
REQ-028 Arbitration SHALL be round-robin: sole requester wins; when both request in the same IDLE cycle, the port not granted last wins.
REQ-029 last_grant SHALL update only on entry to ACCESS.
REQ-030 A req arriving or changing during ACCESS or ACK SHALL be ignored until the next IDLE cycle; it is not lost if still held.
REQ-031 ram_rdata SHALL be ignored outside the ACCESS -> ACK edge, because the RAM drives x when not selected.
REQ-032 The full ADDR_W address SHALL be passed through unmodified, with no range checking.

Reset
REQ-033 While reset is high: state=IDLE; ram_cs, ram_we, ack0, ack1, busy = 0; ram_addr, ram_wdata, rdata0, rdata1 = 0; last_grant = port 1, so port 0 wins the first tie.
REQ-034 Reset asserted in ACCESS or ACK SHALL abandon the transaction: no ack is issued and ram_cs drops immediately (asynchronously).
REQ-035 After reset deassertion, the first request SHALL be sampled on the first rising edge with reset low.

Verification
REQ-036 Write then read: port 0 writes 32'hDEADBEEF to address 5, then reads address 5 -> ack0 at N+1 for each; rdata0=32'hDEADBEEF; ack1 never asserts.
REQ-037 Simultaneous requests after reset: port 0 reads address 3, port 1 reads address 7 -> port 0 is served first, port 1 next at edge N+3; two acks 3 cycles apart.
REQ-038 Fairness: both ports hold req continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 and no port is served twice in a row.
REQ-039 Isolation: port 1 writes 32'h12345678 while rdata0 holds 32'hA5A5A5A5 -> rdata0 stays 32'hA5A5A5A5.
REQ-040 Reset in ACCESS: assert reset mid-cycle during a port 1 write -> ram_cs=0 at once; no ack1; busy=0; the next tie goes to port 0.
REQ-041 Idle bus: no requests for 10 cycles -> ram_cs=0, busy=0, and rdata0/rdata1 never take x values.
